mem_req_ctrl: RTL and testbench

- Request front end that sits directly upstream of the team's single-port synchronous memory.
- Accepts read/write commands on a valid/ready request channel and drives the memory's addr/wr_en/rd_en/wdata pins as registered one-cycle pulses.
- Captures the memory's registered rdata and returns it on a valid/ready response channel, with hold under backpressure.
- Keeps completed-operation counters for debug visibility.

---
 rtl/mem_req_ctrl.sv | 91 +++++++++
 tb/tb_mem_req_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl.sv
// Request front end for the single-port synchronous memory: turns valid/ready
// read/write commands into one-cycle memory pulses and returns read data.
module mem_req_ctrl #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [CNT_WIDTH-1:0]  wr_count,
    output logic [CNT_WIDTH-1:0]  rd_count
);

    typedef enum logic [1:0] {
        IDLE,
        RD_ISSUE,
        RD_CAP,
        RSP
    } state_t;

    state_t state;

    assign req_ready = (state == IDLE);

    // Writes stay in IDLE so they stream at one per cycle; reads walk through
    // the memory's one-cycle registered read before presenting the response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mem_addr  <= '0;
            mem_wr_en <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            wr_count  <= '0;
            rd_count  <= '0;
        end else begin
            mem_wr_en <= 1'b0;
            mem_rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        mem_addr <= req_addr;
                        if (req_write) begin
                            mem_wr_en <= 1'b1;
                            mem_wdata <= req_wdata;
                            if (wr_count != '1)
                                wr_count <= wr_count + CNT_WIDTH'(1);
                        end else begin
                            mem_rd_en <= 1'b1;
                            state     <= RD_ISSUE;
                        end
                    end
                end
                RD_ISSUE: begin
                    state <= RD_CAP;
                end
                RD_CAP: begin
                    rsp_rdata <= mem_rdata;
                    rsp_valid <= 1'b1;
                    state     <= RSP;
                end
                RSP: begin
                    // Data stays put until downstream takes it
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (rd_count != '1)
                            rd_count <= rd_count + CNT_WIDTH'(1);
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: a memory model sits behind the controller and an
// array-based reference predicts read data, pin activity and counters.
module tb_mem_req_ctrl;

    localparam int AW = 2;
    localparam int DW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_write, rsp_ready;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          req_ready, rsp_valid, mem_wr_en, mem_rd_en;
    logic [DW-1:0] rsp_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [CW-1:0] wr_count, rd_count;

    logic          s_req_ready, s_rsp_valid, s_mem_wr_en, s_mem_rd_en;
    logic [DW-1:0] s_rsp_rdata, s_mem_wdata;
    logic [AW-1:0] s_mem_addr;
    logic [1:0]    s_wr_count, s_rd_count;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] ref_mem [4];
    int            ref_wr, ref_rd;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_wdata;

    logic [DW-1:0] mem_array [4];

    mem_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .wr_count(wr_count), .rd_count(rd_count)
    );

    // Narrow-counter instance runs in lockstep to exercise saturation
    mem_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(s_req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(s_rsp_rdata),
        .mem_addr(s_mem_addr), .mem_wr_en(s_mem_wr_en), .mem_rd_en(s_mem_rd_en),
        .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata),
        .wr_count(s_wr_count), .rd_count(s_rd_count)
    );

    always #5 clk = ~clk;

    // Single-port synchronous memory, reset-filled with all-ones
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) mem_array[i] <= 8'hFF;
            mem_rdata <= '0;
        end else begin
            if (mem_wr_en) mem_array[mem_addr] <= mem_wdata;
            if (mem_rd_en) mem_rdata <= mem_array[mem_addr];
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int sat(int n, int mx);
        return (n > mx) ? mx : n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) ref_mem[i] = 8'hFF;
        ref_wr = 0;
        ref_rd = 0;
        last_addr = '0;
        last_wdata = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a write and leaves req_valid high so writes can stream
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL wr_ready: got %b expected 1", req_ready);
        end
        step();
        ref_mem[a] = d; ref_wr++; last_addr = a; last_wdata = d;
        vectors++;
        if ({mem_wr_en, mem_rd_en, mem_addr, mem_wdata} !== {1'b1, 1'b0, a, d}) begin
            miscompares++;
            $display("[TB] FAIL wr_pins: got wr=%b rd=%b addr=%0d wdata=%h expected wr=1 rd=0 addr=%0d wdata=%h",
                     mem_wr_en, mem_rd_en, mem_addr, mem_wdata, a, d);
        end
        vectors++;
        if (wr_count !== CW'(sat(ref_wr, 65535)) || s_wr_count !== 2'(sat(ref_wr, 3))) begin
            miscompares++;
            $display("[TB] FAIL wr_count: got %0d/%0d expected %0d/%0d",
                     wr_count, s_wr_count, sat(ref_wr, 65535), sat(ref_wr, 3));
        end
    endtask

    // Idle cycle with junk on the ignored request fields
    task automatic idle_cycle();
        req_valid = 1'b0; req_write = 1'($urandom); req_addr = AW'($urandom); req_wdata = DW'($urandom);
        step();
        vectors++;
        if ({mem_wr_en, mem_rd_en, mem_addr, mem_wdata, req_ready} !== {1'b0, 1'b0, last_addr, last_wdata, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL idle_hold: got wr=%b rd=%b addr=%0d wdata=%h ready=%b expected 0 0 %0d %h 1",
                     mem_wr_en, mem_rd_en, mem_addr, mem_wdata, req_ready, last_addr, last_wdata);
        end
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int hold);
        logic [DW-1:0] exp_data;
        exp_data = ref_mem[a];
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_wdata = DW'($urandom);
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rd_ready: got %b expected 1", req_ready);
        end
        step();
        req_valid = 1'b0; last_addr = a;
        rsp_ready = 1'($urandom);
        vectors++;
        if ({mem_rd_en, mem_wr_en, mem_addr, req_ready, rsp_valid} !== {1'b1, 1'b0, a, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL rd_issue: got rd=%b wr=%b addr=%0d ready=%b rvalid=%b expected 1 0 %0d 0 0",
                     mem_rd_en, mem_wr_en, mem_addr, req_ready, rsp_valid, a);
        end
        step();
        vectors++;
        if ({mem_rd_en, rsp_valid, req_ready} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL rd_wait: got rd=%b rvalid=%b ready=%b expected 0 0 0",
                     mem_rd_en, rsp_valid, req_ready);
        end
        step();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== exp_data) begin
            miscompares++;
            $display("[TB] FAIL rd_data: got valid=%b data=%h expected 1 %h", rsp_valid, rsp_rdata, exp_data);
        end
        for (int i = 0; i < hold; i++) begin
            rsp_ready = 1'b0;
            step();
            vectors++;
            if ({rsp_valid, rsp_rdata, req_ready} !== {1'b1, exp_data, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL rd_hold: got valid=%b data=%h ready=%b expected 1 %h 0",
                         rsp_valid, rsp_rdata, req_ready, exp_data);
            end
        end
        rsp_ready = 1'b1;
        step();
        ref_rd++;
        rsp_ready = 1'b0;
        vectors++;
        if ({rsp_valid, req_ready} !== 2'b01 || rd_count !== CW'(sat(ref_rd, 65535)) ||
            s_rd_count !== 2'(sat(ref_rd, 3))) begin
            miscompares++;
            $display("[TB] FAIL rd_done: got valid=%b ready=%b cnt=%0d/%0d expected 0 1 %0d/%0d",
                     rsp_valid, req_ready, rd_count, s_rd_count, sat(ref_rd, 65535), sat(ref_rd, 3));
        end
    endtask

    task automatic test_reset();
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        reset = 1'b1;
        model_reset();
        #1;
        vectors++;
        if ({mem_addr, mem_wr_en, mem_rd_en, mem_wdata, rsp_valid, rsp_rdata, wr_count, rd_count} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got addr=%0d wr=%b rd=%b wdata=%h rv=%b rdata=%h wc=%0d rc=%0d expected all 0",
                     mem_addr, mem_wr_en, mem_rd_en, mem_wdata, rsp_valid, rsp_rdata, wr_count, rd_count);
        end
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        step();
        vectors++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_release: got ready=%b rvalid=%b expected 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_read_unwritten();
        do_read(2'd2, 0);
    endtask

    task automatic test_back_to_back();
        do_write(2'd0, 8'h11);
        do_write(2'd1, 8'h22);
        do_write(2'd2, 8'h33);
        do_write(2'd3, 8'h44);
        idle_cycle();
        for (int i = 0; i < 4; i++) do_read(AW'(i), 0);
    endtask

    task automatic test_raw();
        do_write(2'd1, 8'hA5);
        do_read(2'd1, 0);
    endtask

    task automatic test_backpressure();
        do_read(2'd3, 5);
        idle_cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 2))
                0: do_write(AW'($urandom), DW'($urandom));
                1: do_read(AW'($urandom), int'($urandom_range(0, 3)));
                default: idle_cycle();
            endcase
        end
        idle_cycle();
    endtask

    task automatic test_reset_mid_read();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd3;
        step();
        req_valid = 1'b0;
        step();
        #2 reset = 1'b1;
        model_reset();
        #1;
        vectors++;
        if ({rsp_valid, rsp_rdata, mem_addr, mem_wr_en, mem_rd_en, mem_wdata, wr_count, rd_count, s_wr_count, s_rd_count} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_read: got rv=%b rdata=%h addr=%0d wr=%b rd=%b wc=%0d rc=%0d expected all 0",
                     rsp_valid, rsp_rdata, mem_addr, mem_wr_en, mem_rd_en, wr_count, rd_count);
        end
        @(posedge clk);
        #3 reset = 1'b0;
        step();
        step();
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_abort: got rvalid=%b ready=%b expected 0 1", rsp_valid, req_ready);
        end
        do_read(2'd3, 1);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) do_write(AW'(i), DW'(8'h60 + i));
        idle_cycle();
        vectors++;
        if (s_wr_count !== 2'd3 || wr_count !== 16'd5) begin
            miscompares++;
            $display("[TB] FAIL saturate: got %0d/%0d expected 3/5", s_wr_count, wr_count);
        end
    endtask

    initial begin
        test_reset();
        test_read_unwritten();
        test_back_to_back();
        test_raw();
        test_backpressure();
        test_random();
        test_reset_mid_read();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
